// File: rtl/regfile_pkg.sv
// Shared constants and the write-queue entry type for the register-file
// write arbiter.
package regfile_pkg;

  localparam int REG_AW    = 5;
  localparam int DATA_W    = 32;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/regfile_wq.sv
// Circular write queue: up to two pushes and one pop per cycle.
// With REGFILE_WRITER_FWD_EN defined, the storage and read pointer are also
// exported so the parent can search pending writes for forwarding.
// Callers must use push0 before push1; push1 alone is not supported.
module regfile_wq
  import regfile_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push0_i,
  input  wr_entry_t     push0_data_i,
  input  logic          push1_i,
  input  wr_entry_t     push1_data_i,
  input  logic          pop_i,
  output wr_entry_t     head_o,
`ifdef REGFILE_WRITER_FWD_EN
  output wr_entry_t     entries_o [DEPTH],
  output logic [PW-1:0] rd_ptr_o,
`endif
  output logic [CW-1:0] count_o
);

  wr_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointers and occupancy; pointers wrap because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
  end

  // Pointer and count registers; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents beyond count are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wr_ptr_q] <= push0_data_i;
    if (push1_i) mem_q[wr_ptr_q + PW'(1)] <= push1_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

`ifdef REGFILE_WRITER_FWD_EN
  assign entries_o = mem_q;
  assign rd_ptr_o  = rd_ptr_q;
`endif

endmodule

// File: rtl/regfile_writer.sv
// Register-file write arbiter: merges two result sources into one write
// port, buffering overflow in a small queue and writing oldest first.
// Optional forwarding query of pending writes: define REGFILE_WRITER_FWD_EN.
//
// state  | meaning
// IDLE   | queue empty; A (else B) is written directly
// DRAIN  | queue holds entries; the head is written first
module regfile_writer
  import regfile_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_AW-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              wea,
  output logic [REG_AW-1:0] w1,
  output logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] q_reg,
  output logic              q_hit,
  output logic [DATA_W-1:0] q_data,
  output logic              busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              wea_q;
  logic [REG_AW-1:0] w1_q;
  logic [DATA_W-1:0] wdata_q;

  logic              rdy;
  logic              a_acc, b_acc;
  wr_entry_t         a_ent, b_ent, head_w, issue_e, push0_e, push1_e;
  logic              issue_vld, pop, push0, push1;
  logic [CW-1:0]     count_w;
`ifdef REGFILE_WRITER_FWD_EN
  wr_entry_t         ent_w [DEPTH];
  logic [PW-1:0]     rd_ptr_w;
`endif

  // Two free slots cover the worst case of both sources spilling at once.
  assign rdy     = !rst && (count_w <= CW'(DEPTH - 2));
  assign a_ready = rdy;
  assign b_ready = rdy;

  // Writes to x0 are accepted but dropped here.
  assign a_acc = a_valid && rdy && (a_rd != '0);
  assign b_acc = b_valid && rdy && (b_rd != '0);
  assign a_ent = '{rd: a_rd, data: a_data};
  assign b_ent = '{rd: b_rd, data: b_data};

  // Pick the oldest candidate for the write port and spill the rest in order.
  always_comb begin
    issue_vld = 1'b0;
    issue_e   = a_ent;
    pop       = 1'b0;
    push0     = 1'b0;
    push0_e   = a_ent;
    push1     = 1'b0;
    push1_e   = b_ent;
    if (state_q == ST_DRAIN) begin
      issue_vld = 1'b1;
      issue_e   = head_w;
      pop       = 1'b1;
      if (a_acc) begin
        push0 = 1'b1;
        push1 = b_acc;
      end else if (b_acc) begin
        push0   = 1'b1;
        push0_e = b_ent;
      end
    end else if (a_acc) begin
      issue_vld = 1'b1;
      if (b_acc) begin
        push0   = 1'b1;
        push0_e = b_ent;
      end
    end else if (b_acc) begin
      issue_vld = 1'b1;
      issue_e   = b_ent;
    end
  end

  // Controller: DRAIN while anything is queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (push0) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && count_w == CW'(1) && !push0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered write port; address/data hold when no write is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wea_q   <= 1'b0;
      w1_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wea_q   <= issue_vld;
      if (issue_vld) begin
        w1_q    <= issue_e.rd;
        wdata_q <= issue_e.data;
      end
    end
  end

  regfile_wq #(.DEPTH(DEPTH)) u_wq (
    .clk          (clk),
    .rst          (rst),
    .push0_i      (push0),
    .push0_data_i (push0_e),
    .push1_i      (push1),
    .push1_data_i (push1_e),
    .pop_i        (pop),
    .head_o       (head_w),
`ifdef REGFILE_WRITER_FWD_EN
    .entries_o    (ent_w),
    .rd_ptr_o     (rd_ptr_w),
`endif
    .count_o      (count_w)
  );

  assign wea   = wea_q;
  assign w1    = w1_q;
  assign wdata = wdata_q;
  assign busy  = wea_q || (count_w != '0);

`ifdef REGFILE_WRITER_FWD_EN
  // Search oldest to newest so the newest pending value for q_reg wins.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    if (q_reg != '0) begin
      if (wea_q && (w1_q == q_reg)) begin
        q_hit  = 1'b1;
        q_data = wdata_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((CW'(k) < count_w) && (ent_w[rd_ptr_w + PW'(k)].rd == q_reg)) begin
          q_hit  = 1'b1;
          q_data = ent_w[rd_ptr_w + PW'(k)].data;
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^q_reg;
  assign q_hit      = 1'b0;
  assign q_data     = '0;
`endif

endmodule
